// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-timing constants.
// Parity support is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned TICK_W             = 4;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/m_uart_tx_if.sv
// Byte-source valid/ready handshake into the UART transmitter.
// parity_odd exists only when UART_TX_PARITY_EN is defined.
interface m_uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
    logic                 parity_odd;

    modport master (output tx_data, tx_valid, parity_odd, input tx_ready);
    modport slave  (input tx_data, tx_valid, parity_odd, output tx_ready);
`else
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
`endif
endinterface

// File: rtl/m_uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// timed by a 16x oversample tick. Parity enabled by UART_TX_PARITY_EN.
module m_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_tx_16baudrate,
    m_uart_tx_if.slave  bus,
    output logic        txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int unsigned BIT_W = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e              state, state_nxt;
    logic [TICK_W-1:0]      tick_cnt, tick_nxt;
    logic [BIT_W-1:0]       bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]   shift, shift_nxt;
    logic                   txd_nxt;
    logic                   tx_ready_q, ready_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;
    logic                   bit_end_c;
`ifdef UART_TX_PARITY_EN
    logic                   par_bit, par_nxt;
`endif

    assign bus.tx_ready = tx_ready_q;
    assign bit_end_c    = clk_tx_16baudrate && (tick_cnt == TICK_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= TX_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            txd        <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            txd        <= txd_nxt;
            tx_ready_q <= ready_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit    <= par_nxt;
`endif
        end
    end

    // Next-state, counter and line-level logic
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        txd_nxt   = txd;
        ready_nxt = tx_ready_q;
        busy_nxt  = tx_busy;
        done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_bit;
`endif

        // Ticks only advance bit timing once a frame is in flight
        if (state != TX_IDLE && clk_tx_16baudrate) begin
            tick_nxt = bit_end_c ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    shift_nxt = bus.tx_data;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = TX_START;
                    txd_nxt   = 1'b0;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = (^bus.tx_data) ^ bus.parity_odd;
`endif
                end
            end

            TX_START: begin
                if (bit_end_c) begin
                    state_nxt = TX_DATA;
                    txd_nxt   = shift[0];
                end
            end

            TX_DATA: begin
                if (bit_end_c) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = TX_PARITY;
                        txd_nxt   = par_bit;
`else
                        state_nxt = TX_STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        txd_nxt = shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end_c) begin
                    state_nxt = TX_STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif

            TX_STOP: begin
                if (bit_end_c) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = TX_IDLE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = TX_IDLE;
                txd_nxt   = 1'b1;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/m_uart_tx.md
Name: m_uart_tx

Overview:
- UART transmitter; the stage directly downstream of the baud clock generator.
- Consumes the single-cycle 16x-oversample tick (`clk_tx_16baudrate`) and serialises one byte per frame onto `txd`.
- Frame format: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
- Upstream byte source uses a valid/ready handshake.

Parameters:
- DATA_BITS, 8: data bits per frame; legal 5..8.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- OVERSAMPLE, 16: ticks per bit period; must match the baud generator's 16x rate.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- reset  input  1  synchronous reset, active-high.
- clk_tx_16baudrate  input  1  one-clk-wide tick at 16x baud, from the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  high only in IDLE; handshake occurs when tx_valid && tx_ready at a clk edge.
- txd  output  1  serial line; idle high.
- tx_busy  output  1  high from the handshake cycle until the frame ends.
- tx_done  output  1  one-clk pulse on the cycle the final stop bit completes.

Behaviour:
- Reset values:
  - txd=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State=IDLE, tick counter=0, bit counter=0, shift register=0.
- Reset mid-frame: frame abandoned; txd returns high on the next edge; no tx_done.
- States:
  - IDLE: accepts a byte.
  - START: txd=0.
  - DATA: txd = shift[0].
  - PARITY: present only with the optional feature.
  - STOP: txd=1.
- Handshake in IDLE:
  - shift <= tx_data.
  - tick_cnt <= 0, bit_cnt <= 0.
  - State -> START; txd goes low on the same edge, i.e. visible the cycle after the handshake.
  - tx_ready drops and tx_busy rises on that same edge.
- Bit timing:
  - tick_cnt (4 bits) increments on each clk_tx_16baudrate.
  - A bit ends on the tick arriving with tick_cnt==OVERSAMPLE-1; tick_cnt wraps to 0 and the next bit starts on that edge.
  - The start bit is shortened by the tick phase at acceptance (< 1 tick period, ≤1/16 bit). This is accepted behaviour.
- DATA: at each bit end, shift right by 1 and bit_cnt++. After the bit with bit_cnt==DATA_BITS-1, go to PARITY (if enabled) or STOP.
- STOP:
  - Lasts STOP_BITS*OVERSAMPLE ticks.
  - At its end: state -> IDLE, tx_done=1 for one cycle, tx_busy=0, tx_ready=1.
- Frame length: (1+DATA_BITS+STOP_BITS)*OVERSAMPLE ticks, i.e. 160 ticks for 8N1.
- Back-to-back frames:
  - tx_valid held high is accepted on the first IDLE cycle.
  - Minimum gap between the end of a stop bit and the next start bit: 1 clk.
- Held-high tick: a tick held high for more than one cycle counts once per cycle. Ticks are one-clk pulses by contract; no edge detection is done.
- Ignored inputs:
  - tx_data/tx_valid changes while busy are ignored.
  - A tick in the same cycle as the handshake is ignored; counting starts from 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit), sampled with tx_data at the handshake.
  - PARITY state between DATA and STOP, one bit period long.
  - txd = XOR of the data bits, XORed with parity_odd (even parity when 0).
  - Frame grows by OVERSAMPLE ticks.
- Undefined: no parity_odd port; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - tx state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit.
  - OVERSAMPLE default 16.
  - Bit-period tick-count width 4.
- No sub-module; tick/bit counters and the shift register live in one module of roughly 150–250 lines.

Test Plan:
- 8N1, tick every 4 clks, send 0x55 → txd sequence 0,1,0,1,0,1,0,1,0,1; each bit 64 clks (start may be up to 3 clks short); tx_done pulses once; tx_busy high for ~640 clks.
- tx_valid held high with 0xA3 then 0x0F → two frames; data LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; exactly 1 clk of idle high between the stop bit and the next start bit.
- Assert reset during DATA bit 3 → next edge: txd=1, tx_ready=1, tx_busy=0, no tx_done; a subsequent 0xFF frame is correct.
- STOP_BITS=2, send 0x00 → txd low for 9 bit periods, then high for 32 ticks before tx_ready rises.
- UART_TX_PARITY_EN, parity_odd=0: 0x07 gives parity bit 1; 0x03 gives 0. parity_odd=1 inverts both. Frame is 176 ticks.
- tx_valid pulsed while busy with 0x99 → ignored; the in-flight byte is unchanged and tx_ready stays low.
